// File: rtl/clock_div_controller.sv
// Run-time-programmable clock divider: square wave, period tick and 4-channel scan select.
// Optional tick_count output is enabled by defining CLKDIV_TICK_COUNT_EN.
module clock_div_controller #(
    parameter int WIDTH           = 28,
    parameter int DEFAULT_DIVISOR = 200000
) (
    input  logic             clock_in,
    input  logic             reset_n,
    input  logic             enable,
    input  logic [WIDTH-1:0] cfg_divisor,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    output logic             clock_out,
    output logic             tick,
    output logic [1:0]       ch_sel,
    output logic [3:0]       ch_onehot,
    output logic             busy
`ifdef CLKDIV_TICK_COUNT_EN
    ,
    output logic [15:0]      tick_count
`endif
);

    typedef enum logic [1:0] {IDLE, RUN, PENDING} state_t;

    localparam logic [WIDTH-1:0] DEF_DIV = WIDTH'(DEFAULT_DIVISOR);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] counter_q, counter_d;
    logic [WIDTH-1:0] div_q, div_d;
    logic [WIDTH-1:0] pend_q, pend_d;
    logic             clk_out_q, clk_out_d;
    logic             tick_q, tick_d;
    logic [1:0]       ch_sel_q, ch_sel_d;
    logic             xfer;
    logic             wrap;

    // Divisors below 2 would make div-1 underflow and the wave degenerate.
    function automatic logic [WIDTH-1:0] clamp_div(input logic [WIDTH-1:0] d);
        return (d < WIDTH'(2)) ? WIDTH'(2) : d;
    endfunction

    assign cfg_ready = (state_q != PENDING);
    assign busy      = (state_q != IDLE);
    assign xfer      = cfg_valid && cfg_ready;
    assign wrap      = busy && (counter_q == div_q - WIDTH'(1));

    always_ff @(posedge clock_in or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            counter_q <= '0;
            div_q     <= DEF_DIV;
            pend_q    <= '0;
            clk_out_q <= 1'b0;
            tick_q    <= 1'b0;
            ch_sel_q  <= 2'd0;
        end else begin
            state_q   <= state_d;
            counter_q <= counter_d;
            div_q     <= div_d;
            pend_q    <= pend_d;
            clk_out_q <= clk_out_d;
            tick_q    <= tick_d;
            ch_sel_q  <= ch_sel_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        counter_d = counter_q;
        div_d     = div_q;
        pend_d    = pend_q;
        clk_out_d = 1'b0;
        tick_d    = 1'b0;
        ch_sel_d  = ch_sel_q;
        case (state_q)
            IDLE: begin
                counter_d = '0;
                ch_sel_d  = 2'd0;
                if (xfer) div_d = clamp_div(cfg_divisor);
                if (enable) state_d = RUN;
            end
            default: begin
                clk_out_d = (counter_q < (div_q >> 1));
                tick_d    = wrap;
                if (wrap) begin
                    counter_d = '0;
                    ch_sel_d  = ch_sel_q + 2'd1;
                    state_d   = RUN;
                    if (state_q == PENDING) div_d = pend_q;
                    // A divisor offered on the wrap itself waits a full period,
                    // unless we are stopping, in which case it is simply loaded.
                    if (xfer) begin
                        if (enable) begin
                            pend_d  = clamp_div(cfg_divisor);
                            state_d = PENDING;
                        end else begin
                            div_d = clamp_div(cfg_divisor);
                        end
                    end
                    if (!enable) begin
                        state_d   = IDLE;
                        ch_sel_d  = 2'd0;
                        clk_out_d = 1'b0;
                    end
                end else begin
                    counter_d = counter_q + WIDTH'(1);
                    if (xfer) begin
                        pend_d  = clamp_div(cfg_divisor);
                        state_d = PENDING;
                    end
                end
            end
        endcase
    end

    assign clock_out = clk_out_q;
    assign tick      = tick_q;
    assign ch_sel    = ch_sel_q;
    assign ch_onehot = busy ? (4'b0001 << ch_sel_q) : 4'b0000;

`ifdef CLKDIV_TICK_COUNT_EN
    logic [15:0] tick_count_q, tick_count_d;

    always_comb begin
        tick_count_d = tick_count_q;
        if (busy && state_d == IDLE) tick_count_d = 16'd0;
        else if (wrap)               tick_count_d = tick_count_q + 16'd1;
    end

    always_ff @(posedge clock_in or negedge reset_n) begin
        if (!reset_n) tick_count_q <= 16'd0;
        else          tick_count_q <= tick_count_d;
    end

    assign tick_count = tick_count_q;
`endif

endmodule

// File: tb/tb_clock_div_controller.sv
// Randomized bench for clock_div_controller against a period-level behavioural model.
module tb_clock_div_controller;

    localparam int W = 28;

    logic          clock_in = 1'b0;
    logic          reset_n;
    logic          enable;
    logic [W-1:0]  cfg_divisor;
    logic          cfg_valid;
    logic          cfg_ready;
    logic          clock_out;
    logic          tick;
    logic [1:0]    ch_sel;
    logic [3:0]    ch_onehot;
    logic          busy;

    clock_div_controller #(.WIDTH(W), .DEFAULT_DIVISOR(10)) dut (
        .clock_in   (clock_in),
        .reset_n    (reset_n),
        .enable     (enable),
        .cfg_divisor(cfg_divisor),
        .cfg_valid  (cfg_valid),
        .cfg_ready  (cfg_ready),
        .clock_out  (clock_out),
        .tick       (tick),
        .ch_sel     (ch_sel),
        .ch_onehot  (ch_onehot),
        .busy       (busy)
    );

    always #5 clock_in = ~clock_in;

    int n_checks = 0;
    int n_fail   = 0;

    // Model: running flag, position within the current period, active divisor,
    // an optional pending divisor, and the registered outputs.
    bit m_run;
    int m_pos;
    int m_div;
    bit m_has_pend;
    int m_pend;
    bit m_clk;
    bit m_tick;
    int m_ch;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int clampd(input int d);
        return (d < 2) ? 2 : d;
    endfunction

    task automatic model_reset();
        m_run = 0; m_pos = 0; m_div = 10; m_has_pend = 0; m_pend = 0;
        m_clk = 0; m_tick = 0; m_ch = 0;
    endtask

    task automatic model_edge(input bit en, input bit v, input int d);
        bit last;
        bit accepted;
        if (!m_run) begin
            m_tick = 0;
            m_clk  = 0;
            m_ch   = 0;
            if (v) m_div = clampd(d);
            if (en) begin
                m_run = 1;
                m_pos = 0;
            end
        end else begin
            accepted = v && !m_has_pend;
            last     = (m_pos == m_div - 1);
            m_clk    = (m_pos < m_div / 2);
            m_tick   = last;
            if (last) begin
                m_ch  = (m_ch + 1) % 4;
                m_pos = 0;
                if (m_has_pend) begin
                    m_div      = m_pend;
                    m_has_pend = 0;
                end
                if (accepted) begin
                    if (en) begin
                        m_has_pend = 1;
                        m_pend     = clampd(d);
                    end else begin
                        m_div = clampd(d);
                    end
                end
                if (!en) begin
                    m_run = 0;
                    m_clk = 0;
                    m_ch  = 0;
                end
            end else begin
                m_pos++;
                if (accepted) begin
                    m_has_pend = 1;
                    m_pend     = clampd(d);
                end
            end
        end
    endtask

    task automatic check_outputs(input string ph);
        check_eq({ph, ".clock_out"}, 32'(clock_out), 32'(m_clk));
        check_eq({ph, ".tick"},      32'(tick),      32'(m_tick));
        check_eq({ph, ".ch_sel"},    32'(ch_sel),    32'(m_ch));
        check_eq({ph, ".ch_onehot"}, 32'(ch_onehot), m_run ? (32'd1 << m_ch) : 32'd0);
        check_eq({ph, ".busy"},      32'(busy),      32'(m_run));
        check_eq({ph, ".cfg_ready"}, 32'(cfg_ready), 32'(!m_has_pend));
    endtask

    // Called just after a falling edge: drive, clock once, then compare.
    task automatic cycle(input bit en, input bit v, input int d);
        enable      = en;
        cfg_valid   = v;
        cfg_divisor = W'(d);
        #1 check_eq("cfg_ready_pre", 32'(cfg_ready), 32'(!m_has_pend));
        @(posedge clock_in);
        model_edge(en, v, d);
        @(negedge clock_in);
        check_outputs("cyc");
    endtask

    task automatic run_cycles(input int n);
        for (int k = 0; k < n; k++) cycle(1, 0, 0);
    endtask

    task automatic run_to_pos(input int p);
        for (int k = 0; k < 64 && !(m_run && m_pos == p); k++) cycle(1, 0, 0);
    endtask

    task automatic stop_to_idle();
        for (int k = 0; k < 64 && m_run; k++) cycle(0, 0, 0);
        check_eq("stop_busy", 32'(busy), 32'd0);
    endtask

    task automatic load_idle(input int d);
        cycle(0, 1, d);
    endtask

    int ticks_seen;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n     = 1'b0;
        enable      = 1'b0;
        cfg_valid   = 1'b0;
        cfg_divisor = '0;
        model_reset();
        #12;
        check_eq("rst.clock_out", 32'(clock_out), 32'd0);
        check_eq("rst.tick",      32'(tick),      32'd0);
        check_eq("rst.ch_sel",    32'(ch_sel),    32'd0);
        check_eq("rst.ch_onehot", 32'(ch_onehot), 32'd0);
        check_eq("rst.cfg_ready", 32'(cfg_ready), 32'd1);
        check_eq("rst.busy",      32'(busy),      32'd0);
        @(negedge clock_in);
        reset_n = 1'b1;

        // Default divisor 10: four ticks within 41 edges of enabling.
        ticks_seen = 0;
        for (int k = 0; k < 41; k++) begin
            cycle(1, 0, 0);
            if (tick) ticks_seen++;
        end
        check_eq("default_tick_count", 32'(ticks_seen), 32'd4);
        stop_to_idle();

        // Divisor 6 loaded in IDLE.
        load_idle(6);
        run_cycles(30);
        stop_to_idle();

        // Change from 10 to 4 mid-period.
        load_idle(10);
        run_to_pos(3);
        cycle(1, 1, 4);
        check_eq("pend_ready", 32'(cfg_ready), 32'd0);
        run_cycles(25);
        stop_to_idle();

        // Divisor 0 clamps to 2.
        load_idle(0);
        run_cycles(12);
        stop_to_idle();

        // Stop requested at counter 3 of a 10-cycle period.
        load_idle(10);
        run_to_pos(3);
        stop_to_idle();

        // Stop cancelled before the wrap.
        run_to_pos(3);
        cycle(0, 0, 0);
        cycle(0, 0, 0);
        run_cycles(20);

        // Asynchronous reset with a divisor pending.
        load_idle(12);
        stop_to_idle();
        run_to_pos(4);
        cycle(1, 1, 7);
        #2 reset_n = 1'b0;
        #1;
        model_reset();
        check_outputs("arst");
        @(negedge clock_in);
        reset_n = 1'b1;
        run_cycles(25);

        // Randomized traffic.
        for (int k = 0; k < 3000; k++) begin
            cycle($urandom_range(0, 19) != 0, $urandom_range(0, 7) == 0,
                  int'($urandom_range(0, 12)));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
